// File: rtl/cajero_automatico_param.sv
// ATM controller: card acceptance, N-digit PIN with attempt blocking, multi-transaction session with per-session withdrawal limit.
// Optional inactivity timeout enabled by defining CAJERO_TIMEOUT_EN; all outputs registered, responses one cycle after the strobe.
module cajero_automatico_param #(
  parameter int PIN_DIGITS     = 4,
  parameter int MAX_INTENTOS   = 3,
  parameter int MONTO_W        = 32,
  parameter int BALANCE_W      = 64,
  parameter int LIMITE_RETIRO  = 500000,
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tarjeta_recibida,
  input  logic                    digito_stb,
  input  logic [3:0]              digito,
  input  logic [4*PIN_DIGITS-1:0] pin_correcto,
  input  logic                    trans_stb,
  input  logic [1:0]              tipo_trans,
  input  logic [MONTO_W-1:0]      monto,
  input  logic [BALANCE_W-1:0]    balance_inicial,
  output logic                    sesion_activa,
  output logic                    pin_incorrecto,
  output logic                    advertencia,
  output logic                    bloqueo,
  output logic [BALANCE_W-1:0]    balance_actualizado,
  output logic                    balance_stb,
  output logic                    entregar_dinero,
  output logic                    fondos_insuficientes,
  output logic                    limite_excedido,
  output logic                    sesion_expirada
);
  localparam int PW = 4 * PIN_DIGITS;
  localparam int DW = $clog2(PIN_DIGITS + 1);
  localparam int AW = $clog2(MAX_INTENTOS + 1);
  localparam logic [BALANCE_W:0] LIMITE = (BALANCE_W + 1)'(LIMITE_RETIRO);

  typedef enum logic [1:0] {IDLE, PIN, SESION, BLOQUEO} estado_t;

  estado_t                state_q, state_d;
  logic [PW-1:0]          pin_q, pin_d, pin_shift;
  logic [DW-1:0]          dig_q, dig_d;
  logic [AW-1:0]          int_q, int_d, int_inc;
  logic [BALANCE_W-1:0]   bal_q, bal_d, acc_q, acc_d, monto_ext;
  logic [BALANCE_W:0]     dep_sum, ret_sum;
  logic [BALANCE_W-1:0]   bal_out_q, bal_out_d;
  logic sa_q, sa_d, pi_q, pi_d, adv_q, adv_d, blq_q, blq_d;
  logic bs_q, bs_d, ent_q, ent_d, fi_q, fi_d, le_q, le_d;

  assign monto_ext = BALANCE_W'(monto);
  assign dep_sum   = {1'b0, bal_q} + {1'b0, monto_ext};
  assign ret_sum   = {1'b0, acc_q} + {1'b0, monto_ext};
  assign pin_shift = (pin_q << 4) | PW'(digito);
  assign int_inc   = int_q + AW'(1);

`ifdef CAJERO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          exp_q, exp_d;
  assign sesion_expirada = exp_q;
`else
  // No timer exists in this build; the parameter only keeps the interface uniform.
  assign sesion_expirada = (TIMEOUT_CICLOS < 0);
`endif

  always_comb begin
    state_d = state_q;  pin_d = pin_q;  dig_d = dig_q;  int_d = int_q;
    bal_d = bal_q;  acc_d = acc_q;  bal_out_d = bal_out_q;
    sa_d = sa_q;  adv_d = adv_q;  blq_d = blq_q;
    pi_d = 1'b0;  bs_d = 1'b0;  ent_d = 1'b0;  fi_d = 1'b0;  le_d = 1'b0;
    unique case (state_q)
      IDLE: if (tarjeta_recibida) begin
        state_d = PIN;  bal_d = balance_inicial;
        dig_d = '0;  int_d = '0;  pin_d = '0;
      end
      PIN: if (digito_stb && !trans_stb) begin
        if (dig_q == DW'(PIN_DIGITS - 1)) begin
          dig_d = '0;
          pin_d = '0;
          if (pin_shift == pin_correcto) begin
            state_d = SESION;  sa_d = 1'b1;  int_d = '0;  adv_d = 1'b0;
          end else begin
            pi_d  = 1'b1;
            int_d = int_inc;
            adv_d = (int_inc == AW'(MAX_INTENTOS - 1));
            if (int_inc == AW'(MAX_INTENTOS)) begin
              state_d = BLOQUEO;  blq_d = 1'b1;  adv_d = 1'b0;
            end
          end
        end else begin
          dig_d = dig_q + DW'(1);
          pin_d = pin_shift;
        end
      end
      SESION: if (trans_stb) begin
        unique case (tipo_trans)
          2'b00: begin
            bal_d = dep_sum[BALANCE_W] ? '1 : dep_sum[BALANCE_W-1:0];
            bal_out_d = bal_d;  bs_d = 1'b1;
          end
          2'b01: begin
            // Funds are checked before the session limit.
            if (monto_ext > bal_q) fi_d = 1'b1;
            else if (ret_sum > LIMITE) le_d = 1'b1;
            else begin
              bal_d = bal_q - monto_ext;  acc_d = ret_sum[BALANCE_W-1:0];
              bal_out_d = bal_d;  bs_d = 1'b1;  ent_d = 1'b1;
            end
          end
          2'b10: begin
            bal_out_d = bal_q;  bs_d = 1'b1;
          end
          default: begin
            state_d = IDLE;  sa_d = 1'b0;  acc_d = '0;
          end
        endcase
      end
      default: ;
    endcase
`ifdef CAJERO_TIMEOUT_EN
    tmo_d = '0;
    exp_d = 1'b0;
    if (state_q == PIN || state_q == SESION) begin
      if (digito_stb || trans_stb) tmo_d = '0;
      else if (tmo_q == TW'(TIMEOUT_CICLOS - 1)) begin
        state_d = IDLE;  exp_d = 1'b1;  sa_d = 1'b0;  acc_d = '0;
        int_d = '0;  adv_d = 1'b0;  dig_d = '0;  pin_d = '0;
      end else tmo_d = tmo_q + TW'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;  pin_q <= '0;  dig_q <= '0;  int_q <= '0;
      bal_q <= '0;  acc_q <= '0;  bal_out_q <= '0;
      sa_q <= 1'b0;  pi_q <= 1'b0;  adv_q <= 1'b0;  blq_q <= 1'b0;
      bs_q <= 1'b0;  ent_q <= 1'b0;  fi_q <= 1'b0;  le_q <= 1'b0;
`ifdef CAJERO_TIMEOUT_EN
      tmo_q <= '0;  exp_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;  pin_q <= pin_d;  dig_q <= dig_d;  int_q <= int_d;
      bal_q <= bal_d;  acc_q <= acc_d;  bal_out_q <= bal_out_d;
      sa_q <= sa_d;  pi_q <= pi_d;  adv_q <= adv_d;  blq_q <= blq_d;
      bs_q <= bs_d;  ent_q <= ent_d;  fi_q <= fi_d;  le_q <= le_d;
`ifdef CAJERO_TIMEOUT_EN
      tmo_q <= tmo_d;  exp_q <= exp_d;
`endif
    end
  end

  assign sesion_activa        = sa_q;
  assign pin_incorrecto       = pi_q;
  assign advertencia          = adv_q;
  assign bloqueo              = blq_q;
  assign balance_actualizado  = bal_out_q;
  assign balance_stb          = bs_q;
  assign entregar_dinero      = ent_q;
  assign fondos_insuficientes = fi_q;
  assign limite_excedido      = le_q;
endmodule

// File: tb/tb_cajero_automatico_param.sv
// Directed bench for cajero_automatico_param: PIN entry, blocking, session transactions, limits, reset and timeout.
module tb_cajero_automatico_param;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tarjeta_recibida = 1'b0;
  logic        digito_stb = 1'b0;
  logic [3:0]  digito = 4'h0;
  logic [15:0] pin_correcto = 16'h1234;
  logic        trans_stb = 1'b0;
  logic [1:0]  tipo_trans = 2'b00;
  logic [31:0] monto = 32'd0;
  logic [63:0] balance_inicial = 64'd1000;
  logic        sesion_activa, pin_incorrecto, advertencia, bloqueo;
  logic [63:0] balance_actualizado;
  logic        balance_stb, entregar_dinero, fondos_insuficientes, limite_excedido, sesion_expirada;
  int checks = 0;
  int failures = 0;

  cajero_automatico_param #(
    .PIN_DIGITS(4), .MAX_INTENTOS(3), .MONTO_W(32), .BALANCE_W(64),
    .LIMITE_RETIRO(500), .TIMEOUT_CICLOS(20)
  ) dut (
    .clk(clk), .reset(reset), .tarjeta_recibida(tarjeta_recibida),
    .digito_stb(digito_stb), .digito(digito), .pin_correcto(pin_correcto),
    .trans_stb(trans_stb), .tipo_trans(tipo_trans), .monto(monto),
    .balance_inicial(balance_inicial), .sesion_activa(sesion_activa),
    .pin_incorrecto(pin_incorrecto), .advertencia(advertencia), .bloqueo(bloqueo),
    .balance_actualizado(balance_actualizado), .balance_stb(balance_stb),
    .entregar_dinero(entregar_dinero), .fondos_insuficientes(fondos_insuficientes),
    .limite_excedido(limite_excedido), .sesion_expirada(sesion_expirada)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dig(input logic [3:0] d);
    digito = d;
    digito_stb = 1'b1;
    tick();
    digito_stb = 1'b0;
  endtask

  task automatic pin4(input logic [15:0] p);
    for (int i = 3; i >= 0; i--) dig(p[4*i +: 4]);
  endtask

  task automatic trans(input logic [1:0] t, input logic [31:0] m);
    tipo_trans = t;
    monto = m;
    trans_stb = 1'b1;
    tick();
    trans_stb = 1'b0;
  endtask

  task automatic card();
    tarjeta_recibida = 1'b1;
    tick();
    tarjeta_recibida = 1'b0;
  endtask

  initial begin
    logic seen_exp;
    tick(); tick();
    chk("rst_sesion", {63'd0, sesion_activa}, 64'd0);
    chk("rst_bloqueo", {63'd0, bloqueo}, 64'd0);
    chk("rst_balance", balance_actualizado, 64'd0);
    chk("rst_pulses", {59'd0, pin_incorrecto, advertencia, balance_stb, entregar_dinero, limite_excedido}, 64'd0);
    reset = 1'b1;
    tick();

    // Correct PIN, then session transactions
    card();
    dig(4'h1); dig(4'h2); dig(4'h3);
    chk("pin_partial", {63'd0, sesion_activa}, 64'd0);
    dig(4'h4);
    chk("pin_ok_sesion", {63'd0, sesion_activa}, 64'd1);
    chk("pin_ok_noinc", {63'd0, pin_incorrecto}, 64'd0);
    trans(2'b00, 32'd500);
    chk("dep_stb", {63'd0, balance_stb}, 64'd1);
    chk("dep_bal", balance_actualizado, 64'd1500);
    tick();
    chk("dep_stb_pulse", {63'd0, balance_stb}, 64'd0);
    chk("dep_bal_hold", balance_actualizado, 64'd1500);
    trans(2'b01, 32'd200);
    chk("ret_flags", {62'd0, entregar_dinero, balance_stb}, 64'd3);
    chk("ret_bal", balance_actualizado, 64'd1300);
    trans(2'b10, 32'd77);
    chk("qry_flags", {62'd0, entregar_dinero, balance_stb}, 64'd1);
    chk("qry_bal", balance_actualizado, 64'd1300);
    trans(2'b01, 32'd2000);
    chk("nsf_flags", {60'd0, fondos_insuficientes, limite_excedido, entregar_dinero, balance_stb}, 64'd8);
    chk("nsf_bal", balance_actualizado, 64'd1300);
    trans(2'b01, 32'd301);
    chk("lim_flags", {60'd0, fondos_insuficientes, limite_excedido, entregar_dinero, balance_stb}, 64'd4);
    trans(2'b01, 32'd300);
    chk("lim_exact_ok", {62'd0, entregar_dinero, limite_excedido}, 64'd2);
    chk("lim_exact_bal", balance_actualizado, 64'd1000);
    trans(2'b01, 32'd0);
    chk("ret_zero", {62'd0, entregar_dinero, balance_stb}, 64'd3);
    chk("ret_zero_bal", balance_actualizado, 64'd1000);
    trans(2'b01, 32'd1);
    chk("lim_after_full", {62'd0, limite_excedido, entregar_dinero}, 64'd2);
    dig(4'h7);
    chk("dig_in_sesion", {63'd0, sesion_activa}, 64'd1);
    trans(2'b11, 32'd0);
    chk("exit_sesion", {63'd0, sesion_activa}, 64'd0);
    chk("exit_bal_hold", balance_actualizado, 64'd1000);

    // New card: accumulator must start from zero
    card();
    pin4(16'h1234);
    trans(2'b01, 32'd400);
    chk("new_card_ret", {62'd0, entregar_dinero, limite_excedido}, 64'd2);
    chk("new_card_bal", balance_actualizado, 64'd600);
    trans(2'b01, 32'd200);
    chk("new_card_lim", {62'd0, entregar_dinero, limite_excedido}, 64'd1);
    chk("new_card_lim_bal", balance_actualizado, 64'd600);

    // Reset mid-session, then mid-PIN
    reset = 1'b0;
    tick();
    chk("rst_mid_sesion", {63'd0, sesion_activa}, 64'd0);
    chk("rst_mid_bal", balance_actualizado, 64'd0);
    reset = 1'b1;
    card();
    dig(4'h1); dig(4'h2);
    reset = 1'b0;
    tick();
    chk("rst_mid_pin", {62'd0, sesion_activa, pin_incorrecto}, 64'd0);
    reset = 1'b1;
    dig(4'h3); dig(4'h4);
    chk("idle_ignores_dig", {63'd0, sesion_activa}, 64'd0);
    card();
    pin4(16'h1234);
    chk("pin_after_rst", {63'd0, sesion_activa}, 64'd1);
    trans(2'b11, 32'd0);

    // Deposit saturation
    balance_inicial = 64'hFFFF_FFFF_FFFF_FF00;
    card();
    pin4(16'h1234);
    trans(2'b00, 32'h200);
    chk("dep_saturate", balance_actualizado, 64'hFFFF_FFFF_FFFF_FFFF);
    trans(2'b11, 32'd0);

    // Wrong PIN three times -> blocked
    balance_inicial = 64'd1000;
    card();
    pin4(16'h9999);
    chk("bad1_flags", {61'd0, pin_incorrecto, advertencia, bloqueo}, 64'd4);
    tick();
    chk("bad1_pulse_end", {63'd0, pin_incorrecto}, 64'd0);
    pin4(16'h9999);
    chk("bad2_flags", {61'd0, pin_incorrecto, advertencia, bloqueo}, 64'd6);
    pin4(16'h9999);
    chk("bad3_flags", {61'd0, pin_incorrecto, advertencia, bloqueo}, 64'd5);
    pin4(16'h1234);
    chk("blocked_pin", {62'd0, sesion_activa, bloqueo}, 64'd1);
    trans(2'b10, 32'd0);
    chk("blocked_trans", {63'd0, balance_stb}, 64'd0);

    // Inactivity in session
    reset = 1'b0;
    tick();
    reset = 1'b1;
    card();
    pin4(16'h1234);
    seen_exp = 1'b0;
`ifdef CAJERO_TIMEOUT_EN
    for (int i = 0; i < 19; i++) begin
      tick();
      seen_exp = seen_exp | sesion_expirada;
    end
    chk("tmo_before", {62'd0, seen_exp, sesion_activa}, 64'd1);
    tick();
    chk("tmo_expire", {62'd0, sesion_expirada, sesion_activa}, 64'd2);
    tick();
    chk("tmo_pulse_end", {63'd0, sesion_expirada}, 64'd0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      seen_exp = seen_exp | sesion_expirada;
    end
    chk("no_tmo", {62'd0, seen_exp, sesion_activa}, 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
